// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter.
// Port A (pipeline writeback) is zero-latency. Port B (multi-cycle unit) results
// are buffered in a small FIFO. A starvation counter bounds how long a non-empty
// FIFO can wait behind port A. pend_mask reports the destinations still queued.
module rf_wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [4:0]  wb_wr,
    input  logic [31:0] wb_wd,
    output logic        wb_stall,
    input  logic        mc_valid,
    output logic        mc_ready,
    input  logic [4:0]  mc_wr,
    input  logic [31:0] mc_wd,
    output logic        rf_write,
    output logic [4:0]  rf_wr,
    output logic [31:0] rf_wd,
    output logic [31:0] pend_mask
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [SC_W-1:0]  STARVE_C = SC_W'(STARVE_MAX);

    // FIFO storage and control state
    logic [4:0]       mem_wr_q [DEPTH];
    logic [4:0]       mem_wr_d [DEPTH];
    logic [31:0]      mem_wd_q [DEPTH];
    logic [31:0]      mem_wd_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SC_W-1:0]  starve_q, starve_d;

    logic fifo_empty_s;
    logic fifo_full_s;
    logic a_req_s;
    logic a_win_s;
    logic b_win_s;
    logic push_s;
    logic pop_s;

    // Grant decision: A writes with wr==0 are not requests, so they never block B
    always_comb begin
        fifo_empty_s = (count_q == {CNT_W{1'b0}});
        fifo_full_s  = (count_q == DEPTH_C);
        a_req_s      = wb_valid && (wb_wr != 5'd0);
        if (fifo_empty_s) begin
            b_win_s = 1'b0;
        end else if (!a_req_s) begin
            b_win_s = 1'b1;
        end else if (fifo_full_s || (starve_q == STARVE_C)) begin
            b_win_s = 1'b1;
        end else begin
            b_win_s = 1'b0;
        end
        a_win_s = a_req_s && !b_win_s;
    end

    // Write-port and handshake outputs; reset forces everything quiet at once
    always_comb begin
        rf_write = 1'b0;
        rf_wr    = 5'd0;
        rf_wd    = 32'd0;
        wb_stall = 1'b0;
        mc_ready = 1'b0;
        if (reset) begin
            rf_write = 1'b0;
        end else begin
            mc_ready = !fifo_full_s;
            wb_stall = a_req_s && b_win_s;
            if (b_win_s) begin
                rf_write = 1'b1;
                rf_wr    = mem_wr_q[rd_ptr_q];
                rf_wd    = mem_wd_q[rd_ptr_q];
            end else if (a_win_s) begin
                rf_write = 1'b1;
                rf_wr    = wb_wr;
                rf_wd    = wb_wd;
            end else begin
                rf_write = 1'b0;
            end
        end
    end

    // Pending mask: one-hot destination of every occupied slot, head included
    always_comb begin
        logic [PTR_W-1:0] off;
        pend_mask = 32'd0;
        off       = {PTR_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            off = PTR_W'(i) - rd_ptr_q;
            if (!reset && ({1'b0, off} < count_q)) begin
                pend_mask[mem_wr_q[i]] = 1'b1;
            end else begin
                pend_mask = pend_mask;
            end
        end
    end

    // Next-state: FIFO push/pop, pointer wrap, starvation counter
    always_comb begin
        push_s   = mc_valid && mc_ready && (mc_wr != 5'd0);
        pop_s    = b_win_s;
        mem_wr_d = mem_wr_q;
        mem_wd_d = mem_wd_q;
        if (push_s) begin
            mem_wr_d[wr_ptr_q] = mc_wr;
            mem_wd_d[wr_ptr_q] = mc_wd;
            wr_ptr_d           = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (fifo_empty_s || b_win_s) begin
            starve_d = {SC_W{1'b0}};
        end else if (a_win_s && (starve_q != STARVE_C)) begin
            starve_d = starve_q + SC_W'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_wr_q[i] <= 5'd0;
                mem_wd_q[i] <= 32'd0;
            end
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            starve_q <= {SC_W{1'b0}};
        end else begin
            mem_wr_q <= mem_wr_d;
            mem_wd_q <= mem_wd_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: a queue-based reference model is
// compared against the DUT every cycle, plus directed literal checks.
module tb_rf_wb_arbiter;

    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 3;

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_wr;
    logic [31:0] wb_wd;
    logic        wb_stall;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_wr;
    logic [31:0] mc_wd;
    logic        rf_write;
    logic [4:0]  rf_wr;
    logic [31:0] rf_wd;
    logic [31:0] pend_mask;

    rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_wr(wb_wr), .wb_wd(wb_wd), .wb_stall(wb_stall),
        .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_wr(mc_wr), .mc_wd(mc_wd),
        .rf_write(rf_write), .rf_wr(rf_wr), .rf_wd(rf_wd), .pend_mask(pend_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  wr;
        logic [31:0] wd;
    } ent_t;

    ent_t q[$];
    int   starve;
    int   tests;
    int   fails;

    // last sampled DUT outputs, for directed literal checks
    logic        s_write, s_stall, s_ready;
    logic [4:0]  s_wr;
    logic [31:0] s_wd, s_mask;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive, compare with model, then advance model at posedge
    task automatic cyc(input bit wv, input logic [4:0] wwr, input logic [31:0] wwd,
                       input bit mv, input logic [4:0] mwr, input logic [31:0] mwd);
        bit          a_req, b_win, a_win, e_ready, e_write, e_stall;
        logic [4:0]  e_wr;
        logic [31:0] e_wd, e_mask;
        int          n;
        @(negedge clk);
        wb_valid = wv; wb_wr = wwr; wb_wd = wwd;
        mc_valid = mv; mc_wr = mwr; mc_wd = mwd;
        #1;
        n       = q.size();
        a_req   = wv && (wwr != 5'd0);
        e_ready = (n < DEPTH);
        b_win   = (n > 0) && (!a_req || n == DEPTH || starve == STARVE_MAX);
        a_win   = a_req && !b_win;
        e_write = a_win || b_win;
        e_stall = a_req && b_win;
        e_wr    = b_win ? q[0].wr : (a_win ? wwr : 5'd0);
        e_wd    = b_win ? q[0].wd : (a_win ? wwd : 32'd0);
        e_mask  = 32'd0;
        foreach (q[k]) e_mask[q[k].wr] = 1'b1;
        s_write = rf_write; s_stall = wb_stall; s_ready = mc_ready;
        s_wr = rf_wr; s_wd = rf_wd; s_mask = pend_mask;
        chk("rf_write", {31'd0, rf_write}, {31'd0, e_write});
        chk("rf_wr", {27'd0, rf_wr}, {27'd0, e_wr});
        chk("rf_wd", rf_wd, e_wd);
        chk("wb_stall", {31'd0, wb_stall}, {31'd0, e_stall});
        chk("mc_ready", {31'd0, mc_ready}, {31'd0, e_ready});
        chk("pend_mask", pend_mask, e_mask);
        @(posedge clk);
        if (b_win) void'(q.pop_front());
        if (mv && e_ready && mwr != 5'd0) q.push_back('{wr: mwr, wd: mwd});
        if (n == 0 || b_win) starve = 0;
        else if (a_win && starve < STARVE_MAX) starve++;
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Assert reset mid-cycle with wb_valid high and check outputs go quiet at once
    task automatic do_reset();
        @(negedge clk);
        wb_valid = 1'b1; wb_wr = 5'd3; wb_wd = 32'h1234_5678;
        mc_valid = 1'b1; mc_wr = 5'd4; mc_wd = 32'd1;
        reset = 1'b1;
        #1;
        chk("rst_rf_write", {31'd0, rf_write}, 32'd0);
        chk("rst_wb_stall", {31'd0, wb_stall}, 32'd0);
        chk("rst_mc_ready", {31'd0, mc_ready}, 32'd0);
        chk("rst_pend_mask", pend_mask, 32'd0);
        q.delete();
        starve = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        wb_valid = 1'b0; mc_valid = 1'b0;
    endtask

    initial begin
        tests = 0; fails = 0; starve = 0;
        reset = 1'b0;
        wb_valid = 1'b0; wb_wr = 5'd0; wb_wd = 32'd0;
        mc_valid = 1'b0; mc_wr = 5'd0; mc_wd = 32'd0;
        do_reset();

        // 1: A path zero latency
        cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        chk("t1_write", {31'd0, s_write}, 32'd1);
        chk("t1_wr", {27'd0, s_wr}, 32'd5);
        chk("t1_wd", s_wd, 32'hDEADBEEF);
        chk("t1_stall", {31'd0, s_stall}, 32'd0);

        // 2: single B beat, written next cycle, mask for one cycle
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h11);
        chk("t2_nobypass", {31'd0, s_write}, 32'd0);
        idle();
        chk("t2_write", {31'd0, s_write}, 32'd1);
        chk("t2_wr", {27'd0, s_wr}, 32'd7);
        chk("t2_wd", s_wd, 32'h11);
        chk("t2_mask", s_mask, 32'h80);
        idle();
        chk("t2_mask_clr", s_mask, 32'd0);

        // 3: starvation bound
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
            chk("t3_a_wins", {27'd0, s_wr}, 32'd3);
            chk("t3_no_stall", {31'd0, s_stall}, 32'd0);
        end
        cyc(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
        chk("t3_b_forced", {27'd0, s_wr}, 32'd9);
        chk("t3_stall", {31'd0, s_stall}, 32'd1);
        cyc(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
        chk("t3_a_back", {27'd0, s_wr}, 32'd3);
        chk("t3_stall_clr", {31'd0, s_stall}, 32'd0);

        // 4: fill the FIFO while A keeps winning
        for (int i = 0; i < DEPTH; i++)
            cyc(1'b1, 5'd2, 32'h22, 1'b1, 5'(10 + i), 32'(100 + i));
        cyc(1'b1, 5'd2, 32'h22, 1'b1, 5'd20, 32'd0);
        chk("t4_full_ready", {31'd0, s_ready}, 32'd0);
        chk("t4_full_stall", {31'd0, s_stall}, 32'd1);
        chk("t4_full_wr", {27'd0, s_wr}, 32'd10);
        chk("t4_full_mask", s_mask, 32'h0003_C00);
        cyc(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'd0);
        chk("t4_ready_back", {31'd0, s_ready}, 32'd1);
        for (int i = 0; i < 4; i++) idle();

        // 5: register 0 on both ports
        cyc(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0);
        chk("t5_a_r0_write", {31'd0, s_write}, 32'd0);
        chk("t5_a_r0_stall", {31'd0, s_stall}, 32'd0);
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h66);
        chk("t5_b_r0_ready", {31'd0, s_ready}, 32'd1);
        idle();
        chk("t5_b_r0_write", {31'd0, s_write}, 32'd0);
        chk("t5_b_r0_mask", s_mask, 32'd0);

        // 6: reset with three entries queued
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 5'd1, 32'h1, 1'b1, 5'(12 + i), 32'(i));
        do_reset();
        idle();
        chk("t6_ready", {31'd0, s_ready}, 32'd1);
        chk("t6_write", {31'd0, s_write}, 32'd0);
        chk("t6_mask", s_mask, 32'd0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)), $urandom,
                    $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
